// File: rtl/mac_pipe.sv
// mac_pipe: two-stage pipelined unsigned multiply-accumulate with valid/ready
// handshake, accumulate mode with clear, and sticky overflow detection.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid, in_ready  input handshake (in_ready = pipeline enable)
//   mode                0 = MAC (A*B+C), 1 = ACC (acc += A*B)
//   clear               zero acc/overflow at this item's stage-2 update
//   A, B, C             WIDTH-bit unsigned operands
//   out_valid, out_ready output handshake
//   DATA_OUT            OW = 2*WIDTH+GUARD bit result
//   overflow            sticky accumulator overflow flag
module mac_pipe #(
  parameter int WIDTH    = 8,
  parameter int GUARD    = 4,
  parameter bit SATURATE = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       mode,
  input  logic                       clear,
  input  logic [WIDTH-1:0]           A,
  input  logic [WIDTH-1:0]           B,
  input  logic [WIDTH-1:0]           C,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2*WIDTH+GUARD-1:0]   DATA_OUT,
  output logic                       overflow
);

  localparam int PW = 2 * WIDTH;
  localparam int OW = 2 * WIDTH + GUARD;

  // Single global enable: the whole pipeline freezes while the output is
  // held and not taken, so every stage sees the same stall.
  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Stage 1 registers
  logic             v1;
  logic [PW-1:0]    p_q;
  logic [WIDTH-1:0] c_q;
  logic             mode_q;
  logic             clear_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1      <= 1'b0;
      p_q     <= '0;
      c_q     <= '0;
      mode_q  <= 1'b0;
      clear_q <= 1'b0;
    end else if (en) begin
      v1      <= in_valid;
      p_q     <= PW'(A) * PW'(B);
      c_q     <= C;
      mode_q  <= mode;
      clear_q <= clear;
    end
  end

  // Stage 2 result / accumulator update
  logic [OW-1:0] acc;
  logic [OW-1:0] base;
  logic [OW-1:0] acc_nxt;
  logic [OW-1:0] res;
  logic [OW:0]   sum;
  logic          ovf_nxt;

  always_comb begin
    base    = clear_q ? '0 : acc;
    sum     = (OW+1)'(base) + (OW+1)'(p_q);
    acc_nxt = acc;
    ovf_nxt = clear_q ? 1'b0 : overflow;
    res     = '0;
    if (!mode_q) begin
      // P + C always fits in 2*WIDTH bits, so MAC mode never overflows.
      res = OW'(p_q) + OW'(c_q);
      if (clear_q) acc_nxt = '0;
    end else begin
      if (sum[OW]) begin
        ovf_nxt = 1'b1;
        acc_nxt = SATURATE ? '1 : sum[OW-1:0];
      end else begin
        acc_nxt = sum[OW-1:0];
      end
      res = acc_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      DATA_OUT  <= '0;
      acc       <= '0;
      overflow  <= 1'b0;
    end else if (en) begin
      out_valid <= v1;
      if (v1) begin
        DATA_OUT <= res;
        acc      <= acc_nxt;
        overflow <= ovf_nxt;
      end
    end
  end

endmodule
